arb_req_agent: RTL
==================

Name: arb_req_agent

Overview:
- Requester-side counterpart of the 4-way round-robin time-slice arbiter: the initiator end of the REQ/GNT interface.
- Accepts per-channel transfer jobs (length in beats) into small per-channel queues. Drives REQ[3:0] to the arbiter and consumes GNT[3:0] one beat per granted cycle.
- Reports beat, last-beat and job-done events, plus grant-protocol anomalies.
- Sits between the four client engines and the shared-resource arbiter.

Parameters:
- LEN_W, 4, width of job length field; job_len==0 encodes 2^LEN_W beats.
- FIFO_DEPTH, 2, per-channel job queue depth (power of 2, >=2).
- CNT_W, 8, width of saturating spurious-grant counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- job_valid  input  4  per-channel job offer
- job_len  input  4*LEN_W  per-channel job length; channel i at bits [i*LEN_W +: LEN_W]
- job_ready  output  4  per-channel queue not full
- REQ  output  4  registered request vector to arbiter
- GNT  input  4  grant vector from arbiter (registered one-hot or zero there)
- beat_fire  output  1  registered; one beat transferred last cycle
- beat_ch  output  2  channel of beat_fire
- beat_last  output  1  beat_fire beat was final beat of its job
- done  output  4  per-channel one-cycle job-complete pulse
- spurious_cnt  output  CNT_W  saturating count of grants to inactive channels
- err  output  1  sticky flag: GNT had more than one bit set

Behaviour:
- Reset (async, rst=1):
  - All queues empty; active[i]=0; rem[i]=0.
  - REQ=0, beat_fire=0, beat_ch=0, beat_last=0, done=0, spurious_cnt=0, err=0.
  - job_ready forced 0 while rst=1; it reads 4'hF after release.
- Queue:
  - job_ready[i] = !full[i], a function of occupancy only; a pop does not raise ready in the same cycle.
  - Push on job_valid[i] & job_ready[i].
  - job_valid while not ready is ignored; the source must hold.
- Channel state per channel, IDLE/ACTIVE; REQ[i] = active[i] registered.
  - IDLE, queue non-empty: at the next edge pop the head, rem[i] = len (0 maps to 2^LEN_W), go ACTIVE.
  - No bypass: push at edge T gives REQ[i]=1 after edge T+1.
- Grant sampling each edge, only when GNT is one-hot:
  - GNT[i] & active[i]: beat_fire=1, beat_ch=i, rem[i]-=1.
  - If rem[i]==1 on that edge: beat_last=1, done[i]=1. Then, if the queue is non-empty, load the next job on the same edge so REQ[i] stays 1 (back-to-back). Otherwise go IDLE and REQ[i]=0 on that edge.
  - GNT[i] & !active[i]: spurious grant, normal after the arbiter's registered lag. No beat; spurious_cnt+=1, saturating at 2^CNT_W-1.
  - GNT==0: no event. beat_fire, beat_last and done are single-cycle pulses, 0 otherwise.
- GNT with two or more bits set:
  - err<=1, sticky until reset.
  - No beats, no rem change, no spurious count that cycle.
- Loss of grant mid-job: rem holds and REQ stays 1 until the remaining beats are granted.
- Width rule: rem is LEN_W+1 bits so that 2^LEN_W is representable.
- Reset mid-job: immediate clear of all state; jobs in flight and queued are discarded with no done pulse.

Test Plan:
- Reset held 3 cycles -> REQ=0, job_ready=0, spurious_cnt=0, err=0. After release job_ready=4'hF.
- Push ch0 len=3 at T -> REQ[0]=1 after T+1. GNT=0001 for 3 cycles -> 3 beat_fire with beat_ch=0, beat_last and done[0] on the 3rd, REQ[0]=0 on the same edge.
- Push ch1 lens 2,1,1 back-to-back -> the 1st loads active and two queue, so job_ready[1]=0. GNT=0010 continuous -> REQ[1] stays 1 throughout, done[1] pulses after beats 2, 3 and 4.
- GNT=0100 with ch2 idle for 300 cycles -> no beat_fire; spurious_cnt saturates at 255.
- ch0 active rem=2, GNT=0011 -> err=1 stays set, rem stays 2. Then GNT=0001 twice -> job completes normally.
- Push ch3 len=0 and grant continuously -> 16 beats before done[3]. Repeat with rst pulsed after beat 5 -> all outputs 0, no done[3], queue empty.

Source files
------------

// File: rtl/arb_req_agent.sv
// Requester-side agent for the 4-way round-robin time-slice arbiter.
// Each channel owns a small job queue. The head job is loaded into an
// active slot that raises REQ. Each granted cycle moves one beat of the
// active job. Grant-protocol anomalies are reported as a saturating
// spurious-grant count and a sticky multi-grant error.
module arb_req_agent #(
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           job_valid,
    input  logic [4*LEN_W-1:0]   job_len,
    output logic [3:0]           job_ready,
    output logic [3:0]           REQ,
    input  logic [3:0]           GNT,
    output logic                 beat_fire,
    output logic [1:0]           beat_ch,
    output logic                 beat_last,
    output logic [3:0]           done,
    output logic [CNT_W-1:0]     spurious_cnt,
    output logic                 err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int REM_W = LEN_W + 1;

    typedef enum logic {CH_IDLE = 1'b0, CH_ACTIVE = 1'b1} ch_state_t;

    ch_state_t          state_q  [4];
    ch_state_t          state_d  [4];
    logic [REM_W-1:0]   rem_q    [4];
    logic [REM_W-1:0]   rem_d    [4];
    logic [LEN_W-1:0]   mem_q    [4][FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q [4];
    logic [PTR_W-1:0]   wr_ptr_q [4];
    logic [OCC_W-1:0]   occ_q    [4];

    logic [3:0]         push_s, pop_s, beat_s, last_s, full_s, empty_s, active_s;
    logic               gnt_multi_s, gnt_onehot_s, spur_s;
    logic [1:0]         gnt_idx_s;
    logic [1:0]         beat_ch_d;

    logic               beat_fire_q, beat_last_q, err_q;
    logic [1:0]         beat_ch_q;
    logic [3:0]         done_q;
    logic [CNT_W-1:0]   spur_cnt_q;

    // A zero length field encodes the maximum job of 2^LEN_W beats.
    function automatic logic [REM_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
        if (len == {LEN_W{1'b0}}) begin
            return {1'b1, {LEN_W{1'b0}}};
        end else begin
            return {1'b0, len};
        end
    endfunction

    // True when two or more grant bits are set.
    function automatic logic multi_hot(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    // Index of the lowest set bit; only meaningful for a one-hot vector.
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (v[k]) begin
                idx = 2'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Grant decode, queue handshakes and per-channel next state.
    always_comb begin
        gnt_multi_s  = multi_hot(GNT);
        gnt_onehot_s = (GNT != 4'd0) && !gnt_multi_s;
        gnt_idx_s    = onehot_index(GNT);
        for (int i = 0; i < 4; i++) begin
            active_s[i] = (state_q[i] == CH_ACTIVE);
            full_s[i]   = (occ_q[i] == OCC_W'(FIFO_DEPTH));
            empty_s[i]  = (occ_q[i] == {OCC_W{1'b0}});
            push_s[i]   = job_valid[i] && !full_s[i];
            beat_s[i]   = gnt_onehot_s && GNT[i] && active_s[i];
            last_s[i]   = beat_s[i] && (rem_q[i] == REM_W'(1));
            pop_s[i]    = !empty_s[i] && (!active_s[i] || last_s[i]);
            state_d[i]  = state_q[i];
            rem_d[i]    = rem_q[i];
            case (state_q[i])
                CH_IDLE: begin
                    if (pop_s[i]) begin
                        state_d[i] = CH_ACTIVE;
                        rem_d[i]   = len_to_beats(mem_q[i][rd_ptr_q[i]]);
                    end else begin
                        state_d[i] = CH_IDLE;
                    end
                end
                CH_ACTIVE: begin
                    if (pop_s[i]) begin
                        rem_d[i]   = len_to_beats(mem_q[i][rd_ptr_q[i]]);
                    end else if (last_s[i]) begin
                        state_d[i] = CH_IDLE;
                        rem_d[i]   = {REM_W{1'b0}};
                    end else if (beat_s[i]) begin
                        rem_d[i]   = rem_q[i] - REM_W'(1);
                    end else begin
                        rem_d[i]   = rem_q[i];
                    end
                end
                default: begin
                    state_d[i] = CH_IDLE;
                    rem_d[i]   = {REM_W{1'b0}};
                end
            endcase
        end
        spur_s = gnt_onehot_s && ((GNT & ~active_s) != 4'd0);
        if (beat_s != 4'd0) begin
            beat_ch_d = gnt_idx_s;
        end else begin
            beat_ch_d = beat_ch_q;
        end
    end

    // Channel state, remaining-beat counters and queue pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i]  <= CH_IDLE;
                rem_q[i]    <= {REM_W{1'b0}};
                rd_ptr_q[i] <= {PTR_W{1'b0}};
                wr_ptr_q[i] <= {PTR_W{1'b0}};
                occ_q[i]    <= {OCC_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
                if (push_s[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   occ_q[i] <= occ_q[i] + OCC_W'(1);
                    2'b01:   occ_q[i] <= occ_q[i] - OCC_W'(1);
                    default: occ_q[i] <= occ_q[i];
                endcase
            end
        end
    end

    // Job length storage; contents are don't-care while a slot is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= job_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Registered event pulses and anomaly reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_fire_q <= 1'b0;
            beat_ch_q   <= 2'd0;
            beat_last_q <= 1'b0;
            done_q      <= 4'd0;
            spur_cnt_q  <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            beat_fire_q <= (beat_s != 4'd0);
            beat_ch_q   <= beat_ch_d;
            beat_last_q <= (last_s != 4'd0);
            done_q      <= last_s;
            if (spur_s && (spur_cnt_q != {CNT_W{1'b1}})) begin
                spur_cnt_q <= spur_cnt_q + CNT_W'(1);
            end
            if (gnt_multi_s) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            REQ[i] = (state_q[i] == CH_ACTIVE);
        end
        job_ready    = ~full_s & {4{~rst}};
        beat_fire    = beat_fire_q;
        beat_ch      = beat_ch_q;
        beat_last    = beat_last_q;
        done         = done_q;
        spurious_cnt = spur_cnt_q;
        err          = err_q;
    end

endmodule
